vc_player: RTL and testbench
============================

Name: vc_player

Overview:
- Value-change playback transmitter. It is the driving end of the sampled-register interface used by the capture DUTs in this codebase.
- Accepts timestamped events {delta, value, last} over a valid/ready stream and buffers them in a small FIFO.
- Drives wave_out so each value appears exactly delta cycles after the previous change.
- Used to replay edited waveforms into capture blocks for dump/compare runs.

Parameters:
- DW, 8, width of the played value and wave_out
- TW, 16, width of the delta field (cycles between changes)
- DEPTH, 4, event FIFO depth; must be a power of 2 and at least 2
- INIT_VAL, 0, wave_out value after reset and after stop

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins playback from IDLE
- stop  in  1  abort; flushes the FIFO and returns to IDLE
- ev_valid  in  1  event offered
- ev_ready  out  1  event accepted when ev_valid && ev_ready
- ev_delta  in  TW  cycles since the previous change
- ev_value  in  DW  value to drive
- ev_last  in  1  final event of the sequence
- wave_out  out  DW  played value (registered)
- wave_chg  out  1  one-cycle pulse in the cycle wave_out takes a new entry's value
- busy  out  1  state is RUN
- done  out  1  high after the last event is applied, until the next start, stop or rst
- underrun  out  1  sticky; an event was due while the FIFO was empty
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: applies when rst is high at a posedge. Results: state=IDLE, FIFO empty, wave_out=INIT_VAL, wave_chg=0, busy=0, done=0, underrun=0, level=0, timer=0.
- ev_ready = !full, in every state; there is no pass-through when full.
  - Push and pop in the same cycle are both legal. Level is unchanged.
  - Events may be preloaded in IDLE and DONE.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. The start edge is the reference edge E0; timer=0.
  - DONE -> RUN on start. Clears done and underrun. FIFO contents are kept.
  - start while in RUN is ignored.
  - RUN -> DONE on the edge that applies an entry with last=1.
  - Any state -> IDLE on stop. Flushes the FIFO, wave_out=INIT_VAL, clears done and underrun. stop has priority over start.
- RUN timing:
  - d_eff = max(ev_delta, 1).
  - timer increments every cycle.
  - The head entry is applied on the edge E_prev + d_eff, where E_prev is the edge of the previous application (E0 for the first entry).
  - On application: wave_out <= value, pop, timer <= 0, and wave_chg is high for the following cycle.
- Underrun: if timer has reached d_eff-1 and the FIFO is empty, the application is due but cannot happen.
  - Set underrun=1, hold wave_out, and stop the timer.
  - The first entry pushed afterwards is applied on the edge after it becomes visible at the head (one cycle after the push edge).
  - That actual edge becomes the new E_prev.
- Simultaneous events: push into an empty FIFO on the edge where the entry is due counts as underrun. There is no bypass.
- Delta width: a TW-bit delta covers up to 2^TW-1 cycles. The timer is TW bits and never wraps, because it is reset on application.
- rst has priority over everything, including mid-count and mid-handshake. A handshake in flight at rst is dropped.

Decomposition:
- Package vc_pkg:
  - typedef vc_event_t {logic last; logic [TW-1:0] delta; logic [DW-1:0] value}
  - state enum vc_state_e {IDLE, RUN, DONE}
  - localparams for default DW and TW
- Sub-module vc_fifo: synchronous FIFO of vc_event_t.
  - Ports: push, pop, flush, full, empty, level, head.
  - Synchronous active-high reset.
  - The top-level block holds the FSM, timer and output register.

Test Plan:
- Reset and idle: rst for 3 cycles, then idle 10 cycles -> wave_out=0x00; busy, done, underrun, level, wave_chg all 0; ev_ready=1.
- Basic playback: preload {2,0x0F,0}, {3,0x0A,0}, {1,0x55,1}, start at E0 -> wave_out=0x0F at E0+2, 0x0A at E0+5, 0x55 at E0+6. wave_chg pulses 3 times; done=1 and busy=0 from E0+6.
- Delta zero and full: push DEPTH events {0,i,i==DEPTH-1} without starting -> ev_ready=0 at level=4. After start, values 0,1,2,3 appear on consecutive edges E0+1..E0+4.
- Underrun: preload {2,0xAA,0}, start, push {1,0xBB,1} at E0+6 -> 0xAA at E0+2; underrun=1 from E0+3; 0xBB at E0+7; done=1.
- Stop mid-run: preload 3 events with delta 5, start, assert stop at E0+7 -> state IDLE, level=0, wave_out=INIT_VAL, wave_chg=0, and no further changes.
- Reset mid-operation: assert rst at E0+3 during a count while pushing -> all outputs at reset values on the next edge. The pushed event is not stored (level=0).

Source files
------------

// File: rtl/vc_pkg.sv
// Shared types for the value-change player: event record, FSM states and default widths.
package vc_pkg;

    localparam int VC_DW    = 8;
    localparam int VC_TW    = 16;
    localparam int VC_DEPTH = 4;

    typedef struct packed {
        logic             last;
        logic [VC_TW-1:0] delta;
        logic [VC_DW-1:0] value;
    } vc_event_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } vc_state_e;

endpackage

// File: rtl/vc_fifo.sv
// Synchronous event FIFO with flush; head is the oldest entry, valid whenever empty_o is low.
module vc_fifo
    import vc_pkg::*;
#(
    parameter type T     = vc_event_t,
    parameter int  DEPTH = VC_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  T                         din_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output T                         head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    T                mem_q [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [LW-1:0]   cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage needs no reset: an entry is only observed after it has been written.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/vc_player.sv
// Value-change playback transmitter: replays buffered {delta, value, last} events onto wave_out
// so each value lands exactly delta cycles after the previous change.
module vc_player
    import vc_pkg::*;
#(
    parameter int             DW       = VC_DW,
    parameter int             TW       = VC_TW,
    parameter int             DEPTH    = VC_DEPTH,
    parameter logic [DW-1:0]  INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     ev_valid,
    output logic                     ev_ready,
    input  logic [TW-1:0]            ev_delta,
    input  logic [DW-1:0]            ev_value,
    input  logic                     ev_last,
    output logic [DW-1:0]            wave_out,
    output logic                     wave_chg,
    output logic                     busy,
    output logic                     done,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    typedef struct packed {
        logic          last;
        logic [TW-1:0] delta;
        logic [DW-1:0] value;
    } ev_t;

    vc_state_e      state_q;
    logic [TW-1:0]  timer_q;
    logic [DW-1:0]  wave_q;
    logic           chg_q;
    logic           under_q;
    logic           stall_q;

    ev_t            head;
    ev_t            din;
    logic           fifo_full;
    logic           fifo_empty;
    logic [TW-1:0]  d_eff;
    logic           apply;
    logic           push;

    assign din      = '{last: ev_last, delta: ev_delta, value: ev_value};
    assign ev_ready = !fifo_full;
    assign push     = ev_valid && ev_ready;

    // A zero delta still costs one cycle; after an underrun stall the head goes out as soon as it exists.
    assign d_eff = (head.delta == '0) ? TW'(1) : head.delta;
    assign apply = (state_q == RUN) && !stop && !fifo_empty &&
                   (stall_q || (timer_q >= d_eff - TW'(1)));

    vc_fifo #(
        .T     (ev_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (apply),
        .flush_i (stop),
        .din_i   (din),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level),
        .head_o  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            wave_q  <= INIT_VAL;
            chg_q   <= 1'b0;
            under_q <= 1'b0;
            stall_q <= 1'b0;
        end else if (stop) begin
            state_q <= IDLE;
            timer_q <= '0;
            wave_q  <= INIT_VAL;
            chg_q   <= 1'b0;
            under_q <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        timer_q <= '0;
                        stall_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (apply) begin
                        wave_q  <= head.value;
                        chg_q   <= 1'b1;
                        timer_q <= '0;
                        stall_q <= 1'b0;
                        if (head.last) begin
                            state_q <= DONE;
                        end
                    end else if (fifo_empty) begin
                        // Nothing to play: the minimum one-cycle gap has elapsed, so this is an underrun.
                        stall_q <= 1'b1;
                        under_q <= 1'b1;
                    end else if (!stall_q) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        timer_q <= '0;
                        under_q <= 1'b0;
                        stall_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wave_out = wave_q;
    assign wave_chg = chg_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign underrun = under_q;

endmodule

// File: tb/tb_vc_player.sv
// Randomized and directed checks of vc_player against an absolute-time event-queue reference model.
module tb_vc_player;

    localparam int DW       = 8;
    localparam int TW       = 16;
    localparam int DEPTH    = 4;
    localparam int LW       = $clog2(DEPTH) + 1;
    localparam int INIT_VAL = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          ev_valid;
    logic          ev_ready;
    logic [TW-1:0] ev_delta;
    logic [DW-1:0] ev_value;
    logic          ev_last;
    logic [DW-1:0] wave_out;
    logic          wave_chg;
    logic          busy;
    logic          done;
    logic          underrun;
    logic [LW-1:0] level;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    vc_player #(
        .DW       (DW),
        .TW       (TW),
        .DEPTH    (DEPTH),
        .INIT_VAL (DW'(INIT_VAL))
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_delta (ev_delta),
        .ev_value (ev_value),
        .ev_last  (ev_last),
        .wave_out (wave_out),
        .wave_chg (wave_chg),
        .busy     (busy),
        .done     (done),
        .underrun (underrun),
        .level    (level)
    );

    // Reference model: events live in a queue, application times are absolute cycle numbers.
    typedef struct {
        int delta;
        int value;
        bit last;
    } ev_s;

    ev_s    mQueue[$];
    bit     mPlaying;
    bit     mFinished;
    bit     mUnder;
    bit     mWaiting;
    int     mWave;
    bit     mChg;
    longint mCycle = 0;
    longint mLastChange;

    function automatic int effDelta(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit p, input bit v,
                                 input int d, input int val, input bit l);
        rst      = r;
        start    = s;
        stop     = p;
        ev_valid = v;
        ev_delta = TW'(d);
        ev_value = DW'(val);
        ev_last  = l;
    endtask

    task automatic modelStep();
        bit accepted;
        ev_s e;
        accepted = ev_valid && (mQueue.size() < DEPTH);
        mCycle++;
        if (rst || stop) begin
            mQueue.delete();
            mPlaying  = 0;
            mFinished = 0;
            mUnder    = 0;
            mWaiting  = 0;
            mWave     = INIT_VAL;
            mChg      = 0;
            return;
        end
        mChg = 0;
        if (mPlaying) begin
            if (mQueue.size() > 0 &&
                (mWaiting || mCycle >= mLastChange + effDelta(mQueue[0].delta))) begin
                e           = mQueue.pop_front();
                mWave       = e.value;
                mChg        = 1;
                mLastChange = mCycle;
                mWaiting    = 0;
                if (e.last) begin
                    mPlaying  = 0;
                    mFinished = 1;
                end
            end else if (mQueue.size() == 0) begin
                mWaiting = 1;
                mUnder   = 1;
            end
        end else if (start) begin
            mPlaying    = 1;
            mFinished   = 0;
            mUnder      = 0;
            mWaiting    = 0;
            mLastChange = mCycle;
        end
        if (accepted) begin
            e.delta = int'(ev_delta);
            e.value = int'(ev_value);
            e.last  = ev_last;
            mQueue.push_back(e);
        end
    endtask

    task automatic checkAll();
        checkOutput("ev_ready", 32'(ev_ready), 32'(mQueue.size() < DEPTH));
        checkOutput("level",    32'(level),    32'(mQueue.size()));
        checkOutput("wave_out", 32'(wave_out), 32'(mWave));
        checkOutput("wave_chg", 32'(wave_chg), 32'(mChg));
        checkOutput("busy",     32'(busy),     32'(mPlaying));
        checkOutput("done",     32'(done),     32'(mFinished));
        checkOutput("underrun", 32'(underrun), 32'(mUnder));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkAll();
    endtask

    task automatic idleInputs();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pushEvent(input int d, input int val, input bit l);
        applyStimulus(0, 0, 0, 1, d, val, l);
        stepCycle();
        idleInputs();
    endtask

    task automatic startPulse();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        stepCycle();
        idleInputs();
    endtask

    task automatic stopPulse();
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        stepCycle();
        idleInputs();
    endtask

    logic [7:0] basicWave [8] = '{8'h00, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0A, 8'h55, 8'h55};

    initial begin
        int chgSeen;

        // Reset and idle
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (3) stepCycle();
        idleInputs();
        repeat (10) stepCycle();
        checkOutput("idle_wave",  32'(wave_out), 32'h00);
        checkOutput("idle_ready", 32'(ev_ready), 32'd1);

        // Basic playback
        pushEvent(2, 8'h0F, 0);
        pushEvent(3, 8'h0A, 0);
        pushEvent(1, 8'h55, 1);
        startPulse();
        chgSeen = 0;
        checkOutput("bp_wave_k0", 32'(wave_out), 32'(basicWave[0]));
        for (int k = 1; k < 8; k++) begin
            stepCycle();
            chgSeen += int'(wave_chg);
            checkOutput($sformatf("bp_wave_k%0d", k), 32'(wave_out), 32'(basicWave[k]));
            if (k == 5) checkOutput("bp_busy_k5", 32'(busy), 32'd1);
            if (k == 6) begin
                checkOutput("bp_done_k6", 32'(done), 32'd1);
                checkOutput("bp_busy_k6", 32'(busy), 32'd0);
            end
        end
        checkOutput("bp_chg_count", 32'(chgSeen), 32'd3);
        stopPulse();

        // Delta zero and full FIFO
        for (int i = 0; i < DEPTH; i++) pushEvent(0, i, i == DEPTH - 1);
        checkOutput("full_ready", 32'(ev_ready), 32'd0);
        checkOutput("full_level", 32'(level),    32'(DEPTH));
        startPulse();
        for (int k = 1; k <= DEPTH; k++) begin
            stepCycle();
            checkOutput($sformatf("dz_wave_k%0d", k), 32'(wave_out), 32'(k - 1));
        end
        checkOutput("dz_done", 32'(done), 32'd1);
        stopPulse();

        // Underrun
        pushEvent(2, 8'hAA, 0);
        startPulse();
        for (int k = 1; k <= 8; k++) begin
            if (k == 6) applyStimulus(0, 0, 0, 1, 1, 8'hBB, 1);
            else        idleInputs();
            stepCycle();
            if (k == 2) checkOutput("ur_wave_k2",  32'(wave_out), 32'hAA);
            if (k == 2) checkOutput("ur_flag_k2",  32'(underrun), 32'd0);
            if (k == 3) checkOutput("ur_flag_k3",  32'(underrun), 32'd1);
            if (k == 6) checkOutput("ur_wave_k6",  32'(wave_out), 32'hAA);
            if (k == 7) checkOutput("ur_wave_k7",  32'(wave_out), 32'hBB);
            if (k == 7) checkOutput("ur_done_k7",  32'(done),     32'd1);
        end
        idleInputs();
        stopPulse();

        // Stop mid-run
        for (int i = 0; i < 3; i++) pushEvent(5, 8'h11 * (i + 1), 0);
        startPulse();
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) applyStimulus(0, 0, 1, 0, 0, 0, 0);
            stepCycle();
            if (k == 5) checkOutput("sp_wave_k5", 32'(wave_out), 32'h11);
        end
        idleInputs();
        checkOutput("sp_level", 32'(level),    32'd0);
        checkOutput("sp_wave",  32'(wave_out), 32'(INIT_VAL));
        checkOutput("sp_busy",  32'(busy),     32'd0);
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            checkOutput("sp_quiet_chg",  32'(wave_chg), 32'd0);
            checkOutput("sp_quiet_wave", 32'(wave_out), 32'(INIT_VAL));
        end

        // Reset mid-operation with a handshake in flight
        pushEvent(5, 8'h77, 0);
        startPulse();
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) applyStimulus(1, 0, 0, 1, 1, 8'h99, 1);
            stepCycle();
        end
        idleInputs();
        checkOutput("rs_level",    32'(level),    32'd0);
        checkOutput("rs_wave",     32'(wave_out), 32'(INIT_VAL));
        checkOutput("rs_busy",     32'(busy),     32'd0);
        checkOutput("rs_underrun", 32'(underrun), 32'd0);
        stepCycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 11) == 0,
                          $urandom_range(0, 79) == 0,
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 255)),
                          $urandom_range(0, 4) == 0);
            stepCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
